// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM state encoding and the 4x4 legacy key map.
// Pure declarations; no clocked logic.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } kp_state_t;

   // Indexed by row*4+col on a 4x4 telephone-style pad.
   localparam logic [3:0] LEGACY_KEYMAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hF, 4'h0, 4'hE, 4'hD
   };

   function automatic logic [3:0] legacy_code(input logic [3:0] idx);
      return LEGACY_KEYMAP[idx];
   endfunction

endpackage

// File: rtl/kp_stable_counter.sv
// Free-running cycle counter with restart; term flags the LIMIT-th enabled cycle, then wraps.
// Single-cycle terminal flag, combinational from the current count; restart has priority over enable.
module kp_stable_counter #(
   parameter int LIMIT = 4,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic term
);

   logic [W-1:0] count;

   assign term = en && !restart && (count == W'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         count <= '0;
      end else if (en) begin
         count <= term ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Scans an active-low keypad matrix, debounces one key at a time and hands out key codes.
// Row input has 2-cycle sync latency; a key arriving while the previous code is unconsumed is dropped and flagged.
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 1000,
   parameter int DEB_CYCLES = 20000,
   parameter int LEGACY_MAP = 1,
   parameter int CODE_W     = 7
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [ROWS-1:0]   Row,
   output logic [COLS-1:0]   Col,
   output logic [CODE_W-1:0] Key_code,
   output logic              Key_valid,
   input  logic              Key_ready,
   output logic              Key_overflow,
   output logic              Key_down
);

   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS);
   localparam bit USE_LEGACY = (LEGACY_MAP != 0) && (ROWS == 4) && (COLS == 4);

   kp_state_t          state;
   logic [ROWS-1:0]    row_meta;
   logic [ROWS-1:0]    row_s;
   logic [COL_W-1:0]   col_idx;
   logic [ROW_W-1:0]   key_row;
   logic [COL_W-1:0]   key_col;
   logic [ROWS-1:0]    deb_pat;

   logic               row_any;
   logic [ROW_W-1:0]   low_row;
   logic [COL_W-1:0]   col_nxt;
   logic [COLS-1:0]    col_nxt_drive;
   logic [CODE_W-1:0]  code_calc;
   int                 key_idx;

   logic               dwell_en;
   logic               dwell_restart;
   logic               dwell_term;
   logic               deb_en;
   logic               deb_restart;
   logic               deb_term;

   assign row_any = (row_s != '1);

   always_comb begin
      low_row = '0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (!row_s[r]) low_row = ROW_W'(r);
      end
   end

   assign col_nxt       = (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
   assign col_nxt_drive = ~(COLS'(1) << col_nxt);

   always_comb begin
      key_idx = int'(key_row) * COLS + int'(key_col);
      if (USE_LEGACY) code_calc = CODE_W'(legacy_code(key_idx[3:0]));
      else            code_calc = CODE_W'(key_idx);
   end

   // The debounce counter only runs while the pattern it is qualifying holds; anything else restarts it.
   assign dwell_en      = (state == SCAN);
   assign dwell_restart = !dwell_en;
   assign deb_en        = ((state == DEBOUNCE) && (row_s == deb_pat)) ||
                          ((state == RELEASE)  && !row_any);
   assign deb_restart   = !deb_en;

   kp_stable_counter #(.LIMIT(SCAN_DIV)) u_dwell (
      .clk     (Clk),
      .rst     (Rst),
      .en      (dwell_en),
      .restart (dwell_restart),
      .term    (dwell_term)
   );

   kp_stable_counter #(.LIMIT(DEB_CYCLES)) u_debounce (
      .clk     (Clk),
      .rst     (Rst),
      .en      (deb_en),
      .restart (deb_restart),
      .term    (deb_term)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         row_meta     <= '1;
         row_s        <= '1;
         state        <= SCAN;
         col_idx      <= '0;
         Col          <= {{(COLS-1){1'b1}}, 1'b0};
         key_row      <= '0;
         key_col      <= '0;
         deb_pat      <= '1;
         Key_code     <= '0;
         Key_valid    <= 1'b0;
         Key_overflow <= 1'b0;
         Key_down     <= 1'b0;
      end else begin
         row_meta     <= Row;
         row_s        <= row_meta;
         Key_overflow <= 1'b0;

         if (Key_valid && Key_ready) Key_valid <= 1'b0;

         case (state)
            SCAN: begin
               if (dwell_term) begin
                  if (row_any) begin
                     key_row <= low_row;
                     key_col <= col_idx;
                     deb_pat <= row_s;
                     state   <= DEBOUNCE;
                  end else begin
                     col_idx <= col_nxt;
                     Col     <= col_nxt_drive;
                  end
               end
            end
            DEBOUNCE: begin
               if (row_s != deb_pat) begin
                  state   <= SCAN;
                  col_idx <= col_nxt;
                  Col     <= col_nxt_drive;
               end else if (deb_term) begin
                  state    <= PRESSED;
                  Key_down <= 1'b1;
                  // A same-cycle handshake frees the slot, so the new code can replace the old one.
                  if (!Key_valid || Key_ready) begin
                     Key_code  <= code_calc;
                     Key_valid <= 1'b1;
                  end else begin
                     Key_overflow <= 1'b1;
                  end
               end
            end
            PRESSED: begin
               if (!row_any) state <= RELEASE;
            end
            RELEASE: begin
               if (deb_term) begin
                  Key_down <= 1'b0;
                  state    <= SCAN;
                  col_idx  <= col_nxt;
                  Col      <= col_nxt_drive;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner: a 4x4 legacy-map instance and a 3x5 raw-map instance
// driven by a switch-matrix model, with expected key codes queued at press time and checked on handshake.
module tb_keypad_matrix_scanner;

   localparam int SD_A = 8;
   localparam int DB_A = 16;
   localparam int SD_B = 6;
   localparam int DB_B = 8;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic       Rst;
   logic       key_ready_a, key_ready_b;
   logic [3:0] row_a, col_a;
   logic [6:0] code_a;
   logic       valid_a, ovf_a, down_a;
   logic [2:0] row_b;
   logic [4:0] col_b;
   logic [6:0] code_b;
   logic       valid_b, ovf_b, down_b;

   logic       pressed_a [4][4];
   logic       pressed_b [3][5];
   logic [3:0] bounce_a;

   int n_checks = 0;
   int n_pass   = 0;
   int n_hs     = 0;
   int n_ovf    = 0;
   int hs0, hs1, ovf0;
   logic [3:0] exp_col, c1;
   logic [6:0] exp_q [$];
   logic [6:0] exp_qb [$];

   keypad_matrix_scanner #(
      .ROWS(4), .COLS(4), .SCAN_DIV(SD_A), .DEB_CYCLES(DB_A), .LEGACY_MAP(1), .CODE_W(7)
   ) dut_a (
      .Clk(Clk), .Rst(Rst), .Row(row_a), .Col(col_a), .Key_code(code_a), .Key_valid(valid_a),
      .Key_ready(key_ready_a), .Key_overflow(ovf_a), .Key_down(down_a)
   );

   keypad_matrix_scanner #(
      .ROWS(3), .COLS(5), .SCAN_DIV(SD_B), .DEB_CYCLES(DB_B), .LEGACY_MAP(0), .CODE_W(7)
   ) dut_b (
      .Clk(Clk), .Rst(Rst), .Row(row_b), .Col(col_b), .Key_code(code_b), .Key_valid(valid_b),
      .Key_ready(key_ready_b), .Key_overflow(ovf_b), .Key_down(down_b)
   );

   // A closed switch pulls its row low only while its column is driven low.
   always_comb begin
      row_a = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed_a[r][c] && !col_a[c]) row_a[r] = 1'b0;
      row_a = row_a & ~bounce_a;
   end

   always_comb begin
      row_b = '1;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 5; c++)
            if (pressed_b[r][c] && !col_b[c]) row_b[r] = 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   always @(negedge Clk) begin
      if (!Rst && valid_a && key_ready_a) begin
         n_hs++;
         chk("key_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("key_code", {25'd0, code_a}, {25'd0, exp_q.pop_front()});
      end
      if (ovf_a) n_ovf++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst         = 1'b1;
      key_ready_a = 1'b1;
      key_ready_b = 1'b0;
      bounce_a    = '0;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) pressed_a[r][c] = 1'b0;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 5; c++) pressed_b[r][c] = 1'b0;
      tick(3);

      chk("rst_col",   col_a,   4'hE);
      chk("rst_code",  code_a,  0);
      chk("rst_valid", valid_a, 0);
      chk("rst_ovf",   ovf_a,   0);
      chk("rst_down",  down_a,  0);
      chk("rst_col_b", col_b,   5'h1E);
      chk("rst_valid_b", valid_b, 0);

      // Idle scan: each column held for SD_A cycles after reset release.
      Rst = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick(1);
         exp_col = ~(4'b0001 << ((k / SD_A) % 4));
         chk("scan_col", col_a, exp_col);
      end
      chk("idle_no_key", n_hs, 0);
      chk("idle_valid", valid_a, 0);

      // Row2/col1 -> legacy code 8, consumed immediately.
      hs0 = n_hs;
      exp_q.push_back(7'h08);
      pressed_a[2][1] = 1'b1;
      for (int i = 0; i < 300 && !down_a; i++) tick(1);
      chk("press_down", down_a, 1);
      tick(2);
      chk("press_one_event", n_hs - hs0, 1);
      chk("press_valid_cleared", valid_a, 0);
      tick(20);
      chk("held_down", down_a, 1);
      chk("held_col", col_a, 4'hD);
      pressed_a[2][1] = 1'b0;
      tick(2 + 1 + DB_A - 1);
      chk("release_hold", down_a, 1);
      tick(1);
      chk("release_clear", down_a, 0);
      chk("release_next_col", col_a, 4'hB);
      chk("release_no_extra", n_hs - hs0, 1);

      // Bounce: row2 low for 2*SD_A cycles (dwell + half of debounce), then released.
      c1 = col_a;
      for (int i = 0; i < 20 && col_a == c1; i++) tick(1);
      c1 = col_a;
      bounce_a = 4'b0100;
      tick(2 * SD_A);
      chk("bounce_col_held", col_a, c1);
      bounce_a = 4'b0000;
      tick(5);
      exp_col = {c1[2:0], c1[3]};
      chk("bounce_next_col", col_a, exp_col);
      tick(40);
      chk("bounce_no_event", n_hs - hs0, 1);
      chk("bounce_down", down_a, 0);

      // Key 0 unconsumed, then key 5 must be dropped with one overflow pulse.
      key_ready_a = 1'b0;
      ovf0 = n_ovf;
      exp_q.push_back(7'h00);
      pressed_a[3][1] = 1'b1;
      for (int i = 0; i < 300 && !valid_a; i++) tick(1);
      chk("k0_valid", valid_a, 1);
      chk("k0_code", code_a, 0);
      pressed_a[3][1] = 1'b0;
      for (int i = 0; i < 100 && down_a; i++) tick(1);
      chk("k0_release", down_a, 0);
      pressed_a[1][1] = 1'b1;
      for (int i = 0; i < 300 && !down_a; i++) tick(1);
      chk("k5_down", down_a, 1);
      tick(2);
      chk("ovf_pulse", n_ovf - ovf0, 1);
      chk("code_retained", code_a, 0);
      chk("valid_retained", valid_a, 1);
      pressed_a[1][1] = 1'b0;
      for (int i = 0; i < 100 && down_a; i++) tick(1);
      key_ready_a = 1'b1;
      tick(2);
      chk("q_drained", exp_q.size(), 0);
      chk("valid_consumed", valid_a, 0);

      // Reset while a key is held in PRESSED; key released during reset.
      hs1 = n_hs;
      exp_q.push_back(7'h01);
      pressed_a[0][0] = 1'b1;
      for (int i = 0; i < 300 && !down_a; i++) tick(1);
      tick(2);
      chk("pre_rst_event", n_hs - hs1, 1);
      chk("pre_rst_down", down_a, 1);
      Rst = 1'b1;
      pressed_a[0][0] = 1'b0;
      tick(1);
      chk("mid_rst_col",   col_a,   4'hE);
      chk("mid_rst_code",  code_a,  0);
      chk("mid_rst_valid", valid_a, 0);
      chk("mid_rst_down",  down_a,  0);
      chk("mid_rst_ovf",   ovf_a,   0);
      Rst = 1'b0;
      tick(150);
      chk("post_rst_no_event", n_hs - hs1, 1);
      chk("post_rst_down", down_a, 0);
      chk("post_rst_valid", valid_a, 0);

      // Raw index map on a 3x5 pad: row2/col4 -> 14.
      chk("b_idle_valid", valid_b, 0);
      exp_qb.push_back(7'd14);
      pressed_b[2][4] = 1'b1;
      for (int i = 0; i < 300 && !valid_b; i++) tick(1);
      chk("b_valid", valid_b, 1);
      chk("b_code", code_b, exp_qb.pop_front());
      chk("b_down", down_b, 1);
      chk("b_ovf", ovf_b, 0);
      pressed_b[2][4] = 1'b0;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
